// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: latches a 64-bit result at issue and commits it after a fixed latency.
// Build option MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10); otherwise those codes are reserved.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | accepting MD ops; MTHI/MTLO write directly
  // RUN   | counting down; pending result commits when counter hits 0
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3,
                         OP_DIVU  = 4'd4, OP_MTHI  = 4'd5, OP_MTLO  = 4'd6,
                         OP_MADD  = 4'd7, OP_MADDU = 4'd8, OP_MSUB  = 4'd9,
                         OP_MSUBU = 4'd10;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [63:0] pend, pend_nx;
  logic        pend_wr, pend_wr_nx;
  logic [31:0] hi_nx, lo_nx;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_u, div_s, uq, ur, sq, sr, quo_s, rem_s;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide done on magnitudes so the 0x80000000 / -1 case wraps cleanly.
  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;
  assign div_u = (b == 32'd0) ? 32'd1 : b;
  assign div_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign uq    = a / div_u;
  assign ur    = a % div_u;
  assign sq    = abs_a / div_s;
  assign sr    = abs_a % div_s;
  assign quo_s = (a[31] ^ b[31]) ? -sq : sq;
  assign rem_s = a[31] ? -sr : sr;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_nx    = pend;
    pend_wr_nx = pend_wr;
    hi_nx      = hi;
    lo_nx      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_nx    = (op == OP_MULT) ? prod_s : prod_u;
              pend_wr_nx = 1'b1;
              cnt_nx     = 4'(MUL_CYCLES);
              state_nx   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_nx    = (op == OP_DIV) ? {rem_s, quo_s} : {ur, uq};
              pend_wr_nx = (b != 32'd0);
              cnt_nx     = 4'(DIV_CYCLES);
              state_nx   = RUN;
            end
            OP_MTHI: hi_nx = a;
            OP_MTLO: lo_nx = a;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              if (op == OP_MADD)       pend_nx = {hi, lo} + prod_s;
              else if (op == OP_MADDU) pend_nx = {hi, lo} + prod_u;
              else if (op == OP_MSUB)  pend_nx = {hi, lo} - prod_s;
              else                     pend_nx = {hi, lo} - prod_u;
              pend_wr_nx = 1'b1;
              cnt_nx     = 4'(MUL_CYCLES);
              state_nx   = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          if (pend_wr) {hi_nx, lo_nx} = pend;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      pend_wr <= pend_wr_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a longint reference model.
// Honours MD_MADD_EN the same way as the design.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] hi_m, lo_m;

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result and busy length from the instruction semantics.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int n, output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    logic [63:0] acc, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    acc = {hi_m, lo_m};
    eh = hi_m; el = lo_m; n = 0;
    case (o)
      4'd1: begin p = 64'(sx * sy); {eh, el} = p; n = 5; end
      4'd2: begin p = 64'(x) * 64'(y); {eh, el} = p; n = 5; end
      4'd3: begin
        n = 10;
        if (y != 0) begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
      end
      4'd4: begin n = 10; if (y != 0) begin el = x / y; eh = x % y; end end
      4'd5: eh = x;
      4'd6: el = x;
`ifdef MD_MADD_EN
      4'd7:  begin p = acc + 64'(sx * sy);  {eh, el} = p; n = 5; end
      4'd8:  begin p = acc + 64'(x) * 64'(y); {eh, el} = p; n = 5; end
      4'd9:  begin p = acc - 64'(sx * sy);  {eh, el} = p; n = 5; end
      4'd10: begin p = acc - 64'(x) * 64'(y); {eh, el} = p; n = 5; end
`endif
      default: ;
    endcase
  endtask

  task automatic exec(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int exp_n, n;
    logic [31:0] eh, el;
    model(o, x, y, exp_n, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 0) check({tag, "_hold"}, {hi, lo}, {hi_m, lo_m});
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(n), 64'(exp_n));
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    int n;
    int exp_n;
    logic [31:0] eh, el, x, y;
    logic [3:0] o;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    exec("mult_neg2x3", 4'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_neg2x3_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    exec("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    exec("div_neg7_2", 4'd3, 32'hFFFFFFF9, 32'd2);
    check("div_neg7_2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    exec("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    exec("mthi", 4'd5, 32'h11, 32'd0);
    exec("mtlo", 4'd6, 32'h22, 32'd0);
    exec("divu_by0", 4'd4, 32'd7, 32'd0);
    check("divu_by0_const", {hi, lo}, 64'h00000011_00000022);
    exec("div_by0", 4'd3, 32'h80000001, 32'd0);
    exec("none", 4'd0, 32'h1234, 32'h5678);
    exec("reserved", 4'd13, 32'h1234, 32'h5678);

    // Start while busy must be ignored.
    model(4'd1, 32'd1000, 32'd7, exp_n, eh, el);
    @(negedge clk); start = 1'b1; op = 4'd1; a = 32'd1000; b = 32'd7;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start = (n == 2); op = 4'd6; a = 32'h55;
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0;
    check("ign_busy_len", 64'(n), 64'(exp_n));
    check("ign_hilo", {hi, lo}, {eh, el});
    hi_m = eh; lo_m = el;
    repeat (2) @(negedge clk);
    check("ign_lo_after", 64'(lo), 64'(el));

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      if (i % 3 == 0) o = 4'($urandom_range(1, 4));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 1) y = 32'($urandom_range(1, 20));
      exec("rand", o, x, y);
    end

    exec("madd_pre_hi", 4'd5, 32'd0, 32'd0);
    exec("madd_pre_lo", 4'd6, 32'hFFFFFFFF, 32'd0);
    exec("maddu_carry", 4'd8, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    check("maddu_carry_const", {hi, lo}, 64'h00000001_00000000);
`else
    check("maddu_carry_const", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif
    exec("madd_s", 4'd7, 32'hFFFFFFFD, 32'd9);
    exec("msub_s", 4'd9, 32'h7FFFFFFF, 32'h80000000);
    exec("msubu", 4'd10, $urandom, $urandom);

    // Reset mid-operation discards the pending result.
    @(negedge clk); start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    @(negedge clk); start = 1'b0; op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 3) begin
      n++;
      if (n < 3) @(negedge clk);
    end
    check("rst_mid_reached", 64'(n), 64'd3);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_update", {31'd0, busy, hi, lo}, 96'd0);
    exec("post_rst_multu", 4'd2, 32'h10000, 32'h10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
